// File: rtl/fdtd_pkg.sv
// Shared types and default widths for the 1D FDTD H-field update.
// Includes the saturation limits used by the update datapath.
package fdtd_pkg;

  localparam int FDTD_DATA_WIDTH   = 32;
  localparam int BUFFER_ADDR_WIDTH = 6;
  localparam int COEF_WIDTH        = 18;
  localparam int FRAC_BITS         = 16;

  typedef enum logic [2:0] {
    IDLE,
    RD_E0,
    RD_E1,
    CALC,
    WR,
    DONE
  } fdtd_upd_state_e;

  function automatic longint sat_hi(input int w);
    return (longint'(1) <<< (w - 1)) - longint'(1);
  endfunction

  function automatic longint sat_lo(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction

endpackage

// File: rtl/fdtd_sat_mac.sv
// Saturating multiply-accumulate: res = sat(h0 + ((e1-e0)*coef >>> FB)).
// Pure combinational; the caller registers the result.
module fdtd_sat_mac #(
  parameter int W  = 32,
  parameter int CW = 18,
  parameter int FB = 16
) (
  input  logic signed [W-1:0]  e0_i,
  input  logic signed [W-1:0]  e1_i,
  input  logic signed [W-1:0]  h0_i,
  input  logic signed [CW-1:0] coef_i,
  output logic signed [W-1:0]  res_o,
  output logic                 sat_o
);
  import fdtd_pkg::*;

  localparam int PW = W + 1 + CW;
  localparam int SW = PW + 1;

  localparam logic signed [SW-1:0] HI = SW'(sat_hi(W));
  localparam logic signed [SW-1:0] LO = SW'(sat_lo(W));

  logic signed [W:0]    diff;
  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] scaled;
  logic signed [SW-1:0] sum;

  assign diff   = (W+1)'(e1_i) - (W+1)'(e0_i);
  assign prod   = PW'(diff) * PW'(coef_i);
  assign scaled = prod >>> FB;
  assign sum    = SW'(scaled) + SW'(h0_i);

  always_comb begin
    res_o = sum[W-1:0];
    sat_o = 1'b0;
    if (sum > HI) begin
      res_o = HI[W-1:0];
      sat_o = 1'b1;
    end else if (sum < LO) begin
      res_o = LO[W-1:0];
      sat_o = 1'b1;
    end
  end

endmodule

// File: rtl/fdtd_h_update.sv
// 1D FDTD H-field sweep: reads E/H buffer RAMs, applies the
// saturating update and writes H[0..L-2] back, 4 cycles per cell.
module fdtd_h_update #(
  parameter int FDTD_DATA_WIDTH   = fdtd_pkg::FDTD_DATA_WIDTH,
  parameter int BUFFER_ADDR_WIDTH = fdtd_pkg::BUFFER_ADDR_WIDTH,
  parameter int BUFFER_RAM_DEPTH  = 64,
  parameter int COEF_WIDTH        = fdtd_pkg::COEF_WIDTH,
  parameter int FRAC_BITS         = fdtd_pkg::FRAC_BITS
) (
  input  logic                                CLK,
  input  logic                                RST_N,
  input  logic                                start,
  input  logic [BUFFER_ADDR_WIDTH:0]          cell_num,
  input  logic signed [COEF_WIDTH-1:0]        coef,
  output logic                                busy,
  output logic                                done,
  output logic                                sat_flag,
  output logic                                e_en,
  output logic                                e_rden,
  output logic [BUFFER_ADDR_WIDTH-1:0]        e_addr,
  input  logic signed [FDTD_DATA_WIDTH-1:0]   e_dout,
  output logic                                h_en,
  output logic                                h_rden,
  output logic                                h_wren,
  output logic [BUFFER_ADDR_WIDTH-1:0]        h_addr_a,
  output logic [BUFFER_ADDR_WIDTH-1:0]        h_addr_b,
  output logic signed [FDTD_DATA_WIDTH-1:0]   h_din,
  input  logic signed [FDTD_DATA_WIDTH-1:0]   h_dout
);
  import fdtd_pkg::*;

  localparam int W  = FDTD_DATA_WIDTH;
  localparam int AW = BUFFER_ADDR_WIDTH;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(BUFFER_RAM_DEPTH);

  fdtd_upd_state_e state_q, state_d;

  logic [AW-1:0]               i_q, i_d;
  logic [AW:0]                 l_q, l_d;
  logic signed [COEF_WIDTH-1:0] coef_q, coef_d;
  logic signed [W-1:0]         e0_q, e0_d;
  logic signed [W-1:0]         e1_q, e1_d;
  logic signed [W-1:0]         h0_q, h0_d;
  logic signed [W-1:0]         res_q, res_d;
  logic                        sat_q, sat_d;

  logic [AW:0]                 l_in;
  logic signed [W-1:0]         mac_res;
  logic                        mac_sat;

  assign l_in     = (cell_num > DEPTH_C) ? DEPTH_C : cell_num;
  assign sat_flag = sat_q;

  fdtd_sat_mac #(
    .W  (W),
    .CW (COEF_WIDTH),
    .FB (FRAC_BITS)
  ) u_mac (
    .e0_i   (e0_q),
    .e1_i   (e1_q),
    .h0_i   (h0_q),
    .coef_i (coef_q),
    .res_o  (mac_res),
    .sat_o  (mac_sat)
  );

  always_comb begin
    state_d  = state_q;
    i_d      = i_q;
    l_d      = l_q;
    coef_d   = coef_q;
    e0_d     = e0_q;
    e1_d     = e1_q;
    h0_d     = h0_q;
    res_d    = res_q;
    sat_d    = sat_q;
    busy     = 1'b1;
    done     = 1'b0;
    e_en     = 1'b0;
    e_rden   = 1'b0;
    e_addr   = '0;
    h_en     = 1'b0;
    h_rden   = 1'b0;
    h_wren   = 1'b0;
    h_addr_a = '0;
    h_addr_b = '0;
    h_din    = '0;
    unique case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          coef_d  = coef;
          l_d     = l_in;
          sat_d   = 1'b0;
          i_d     = '0;
          state_d = (l_in >= (AW+1)'(2)) ? RD_E0 : DONE;
        end
      end
      RD_E0: begin
        e_en    = 1'b1;
        e_rden  = 1'b1;
        e_addr  = i_q;
        e0_d    = e_dout;
        state_d = RD_E1;
      end
      RD_E1: begin
        e_en     = 1'b1;
        e_rden   = 1'b1;
        e_addr   = i_q + AW'(1);
        e1_d     = e_dout;
        h_en     = 1'b1;
        h_rden   = 1'b1;
        h_addr_b = i_q;
        h0_d     = h_dout;
        state_d  = CALC;
      end
      CALC: begin
        res_d   = mac_res;
        sat_d   = sat_q | mac_sat;
        state_d = WR;
      end
      WR: begin
        h_en     = 1'b1;
        h_wren   = 1'b1;
        h_addr_a = i_q;
        h_din    = res_q;
        if ({1'b0, i_q} == l_q - (AW+1)'(2)) begin
          state_d = DONE;
        end else begin
          i_d     = i_q + AW'(1);
          state_d = RD_E0;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      i_q     <= '0;
      l_q     <= '0;
      coef_q  <= '0;
      e0_q    <= '0;
      e1_q    <= '0;
      h0_q    <= '0;
      res_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      l_q     <= l_d;
      coef_q  <= coef_d;
      e0_q    <= e0_d;
      e1_q    <= e1_d;
      h0_q    <= h0_d;
      res_q   <= res_d;
      sat_q   <= sat_d;
    end
  end

endmodule

// File: tb/tb_fdtd_h_update.sv
// Scoreboard bench for fdtd_h_update with behavioural E/H buffer RAMs.
// Expected H writes are queued per sweep and popped by a write monitor.
module tb_fdtd_h_update;

  logic        CLK;
  logic        RST_N;
  logic        start;
  logic [6:0]  cell_num;
  logic [17:0] coef;
  logic        busy, done, sat_flag;
  logic        e_en, e_rden;
  logic [5:0]  e_addr;
  logic [31:0] e_dout;
  logic        h_en, h_rden, h_wren;
  logic [5:0]  h_addr_a, h_addr_b;
  logic [31:0] h_din;
  logic [31:0] h_dout;

  logic [31:0] eram [64];
  logic [31:0] hram [64];
  logic        ld_en;
  logic [5:0]  ld_a;
  logic [31:0] ld_d;

  logic [37:0] sb [$];
  int nchk = 0;
  int nerr = 0;
  int nwr  = 0;
  int last_a = -1;

  fdtd_h_update dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .start    (start),
    .cell_num (cell_num),
    .coef     (coef),
    .busy     (busy),
    .done     (done),
    .sat_flag (sat_flag),
    .e_en     (e_en),
    .e_rden   (e_rden),
    .e_addr   (e_addr),
    .e_dout   (e_dout),
    .h_en     (h_en),
    .h_rden   (h_rden),
    .h_wren   (h_wren),
    .h_addr_a (h_addr_a),
    .h_addr_b (h_addr_b),
    .h_din    (h_din),
    .h_dout   (h_dout)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  assign e_dout = e_rden ? eram[e_addr] : '0;
  assign h_dout = h_rden ? hram[h_addr_b] : '0;

  always @(posedge CLK) begin
    if (ld_en) hram[ld_a] <= ld_d;
    else if (h_en && h_wren) hram[h_addr_a] <= h_din;
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // write monitor / scoreboard consumer
  initial begin
    logic [37:0] e;
    forever begin
      @(negedge CLK);
      if (RST_N && h_en && h_wren) begin
        nwr++;
        last_a = int'(h_addr_a);
        if (sb.size() == 0) begin
          nchk++;
          nerr++;
          $display("FAIL unexpected_write: addr %0d data %0h, none expected",
                   h_addr_a, h_din);
        end else begin
          e = sb.pop_front();
          chk("wr_addr", longint'(h_addr_a), longint'(e[37:32]));
          chk("wr_data", longint'(h_din), longint'(e[31:0]));
        end
      end
    end
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic hset(input int a, input logic [31:0] v);
    ld_en = 1'b1;
    ld_a  = 6'(a);
    ld_d  = v;
    tick();
    ld_en = 1'b0;
  endtask

  task automatic expect_wr(input int a, input logic [31:0] v);
    logic [5:0] a6;
    a6 = 6'(a);
    sb.push_back({a6, v});
  endtask

  task automatic run_sweep(input int cn, input int cf, input int exp_cyc,
                           input int dbl);
    int cyc;
    cell_num = 7'(cn);
    coef     = 18'(cf);
    start    = 1'b1;
    tick();
    start = 1'b0;
    cyc   = 1;
    if (exp_cyc > 1) chk("busy_c1", longint'(busy), 1);
    while (!done && cyc < 400) begin
      if (cyc == dbl) begin
        start    = 1'b1;
        cell_num = 7'd10;
        coef     = 18'h10000;
      end
      tick();
      start = 1'b0;
      cyc++;
    end
    chk("done_cycle", longint'(cyc), longint'(exp_cyc));
    tick();
    chk("done_pulse", longint'(done), 0);
    chk("idle_busy", longint'(busy), 0);
    chk("sb_drained", longint'(sb.size()), 0);
  endtask

  initial begin
    int w0;
    RST_N    = 1'b0;
    start    = 1'b0;
    cell_num = '0;
    coef     = '0;
    ld_en    = 1'b0;
    ld_a     = '0;
    ld_d     = '0;
    for (int k = 0; k < 64; k++) eram[k] = '0;
    #12;
    chk("rst_busy", longint'(busy), 0);
    chk("rst_done", longint'(done), 0);
    chk("rst_sat", longint'(sat_flag), 0);
    chk("rst_strobes", longint'({e_en, e_rden, h_en, h_rden, h_wren}), 0);
    chk("rst_addrs", longint'({e_addr, h_addr_a, h_addr_b}), 0);
    chk("rst_hdin", longint'(h_din), 0);
    @(negedge CLK);
    RST_N = 1'b1;
    tick();

    // basic update, coef 0.5
    eram[0] = 32'd0;
    eram[1] = 32'd4;
    eram[2] = 32'd10;
    for (int k = 0; k < 3; k++) hset(k, 32'd0);
    expect_wr(0, 32'd2);
    expect_wr(1, 32'd3);
    w0 = nwr;
    run_sweep(3, 'h8000, 9, 0);
    chk("basic_nwr", longint'(nwr - w0), 2);
    chk("basic_sat", longint'(sat_flag), 0);
    chk("basic_h2", longint'(hram[2]), 0);

    // second start in cycle 3 is ignored
    for (int k = 0; k < 3; k++) hset(k, 32'd0);
    expect_wr(0, 32'd2);
    expect_wr(1, 32'd3);
    w0 = nwr;
    run_sweep(3, 'h8000, 9, 3);
    chk("dbl_nwr", longint'(nwr - w0), 2);

    // positive saturation
    eram[0] = 32'd0;
    eram[1] = 32'h100;
    hset(0, 32'h7FFF_FFF0);
    expect_wr(0, 32'h7FFF_FFFF);
    run_sweep(2, 'h10000, 5, 0);
    chk("sat_flag_set", longint'(sat_flag), 1);

    // negative diff, floor rounding; new start clears sat_flag
    eram[0] = 32'd5;
    eram[1] = 32'd2;
    hset(0, 32'd10);
    expect_wr(0, 32'd8);
    run_sweep(2, 'h8000, 5, 0);
    chk("sat_flag_clr", longint'(sat_flag), 0);

    // degenerate lengths
    w0 = nwr;
    run_sweep(1, 'h8000, 1, 0);
    run_sweep(0, 'h8000, 1, 0);
    chk("degen_nwr", longint'(nwr - w0), 0);

    // clamp to depth: E all zero so each H keeps its value
    for (int k = 0; k < 64; k++) eram[k] = '0;
    for (int k = 0; k < 64; k++) hset(k, 32'(k * 3 + 1));
    for (int k = 0; k < 63; k++) expect_wr(k, 32'(k * 3 + 1));
    w0 = nwr;
    run_sweep(100, 'h8000, 253, 0);
    chk("clamp_nwr", longint'(nwr - w0), 63);
    chk("clamp_last", longint'(last_a), 62);
    chk("clamp_h63", longint'(hram[63]), 190);

    // reset during RD_E1 of cell 1
    eram[0] = 32'd0;
    eram[1] = 32'd4;
    eram[2] = 32'd10;
    for (int k = 0; k < 3; k++) hset(k, 32'd7);
    expect_wr(0, 32'd9);
    cell_num = 7'd3;
    coef     = 18'h8000;
    start    = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    chk("mid_rd_e1", longint'({h_rden, h_addr_b}), longint'({1'b1, 6'd1}));
    RST_N = 1'b0;
    #1;
    chk("mid_busy", longint'(busy), 0);
    chk("mid_strobes", longint'({e_en, e_rden, h_en, h_rden, h_wren}), 0);
    chk("mid_addr", longint'({e_addr, h_addr_b}), 0);
    tick();
    RST_N = 1'b1;
    tick();
    chk("mid_h0", longint'(hram[0]), 9);
    chk("mid_h1", longint'(hram[1]), 7);
    chk("mid_sb", longint'(sb.size()), 0);

    // fresh sweep after reset
    expect_wr(0, 32'd11);
    expect_wr(1, 32'd10);
    run_sweep(3, 'h8000, 9, 0);
    chk("post_h2", longint'(hram[2]), 7);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/fdtd_h_update.md
Name: fdtd_h_update

Overview:
- Sequencer plus datapath for the 1D FDTD magnetic-field update: H[i] <= sat(H[i] + coef*(E[i+1]-E[i])) for i = 0..cell_num-2.
- Drives two fdtd buffer RAM instances, one holding E and one holding H. Each RAM has a combinational gated read (dout = rden ? ram[addr_b] : 0) and a write on posedge when en && wren.
- Sits directly upstream/downstream of the buffer RAMs: it consumes their read data and produces their write traffic. Launched by the plugin control FSM, one sweep per time step.

Parameters:
- FDTD_DATA_WIDTH, 32, field sample width, signed two's complement.
- BUFFER_ADDR_WIDTH, 6, RAM address width.
- BUFFER_RAM_DEPTH, 64, cells per RAM.
- COEF_WIDTH, 18, signed update-coefficient width.
- FRAC_BITS, 16, fractional bits of coef (Q2.16 by default).

Ports:
- CLK  in  1  clock
- RST_N  in  1  asynchronous active-low reset
- start  in  1  one-cycle launch pulse
- cell_num  in  BUFFER_ADDR_WIDTH+1  number of cells L; sampled on start
- coef  in  COEF_WIDTH  signed coefficient; sampled on start
- busy  out  1  sweep in progress
- done  out  1  one-cycle sweep-complete pulse
- sat_flag  out  1  sticky: some result of the current sweep saturated
- e_en  out  1  E RAM enable
- e_rden  out  1  E RAM read enable
- e_addr  out  BUFFER_ADDR_WIDTH  E RAM read address (addr_b)
- e_dout  in  FDTD_DATA_WIDTH  E RAM read data
- h_en  out  1  H RAM enable
- h_rden  out  1  H RAM read enable
- h_wren  out  1  H RAM write enable
- h_addr_a  out  BUFFER_ADDR_WIDTH  H RAM write address
- h_addr_b  out  BUFFER_ADDR_WIDTH  H RAM read address
- h_din  out  FDTD_DATA_WIDTH  H RAM write data
- h_dout  in  FDTD_DATA_WIDTH  H RAM read data

Behaviour:
- Reset (async, RST_N low): state IDLE. busy, done, sat_flag, all RAM enables and strobes = 0. All addresses and h_din = 0. Index i = 0. Latched coef and L cleared.
- FSM states: IDLE, RD_E0, RD_E1, CALC, WR, DONE.
- IDLE
  - start=1: latch coef, latch L = min(cell_num, BUFFER_RAM_DEPTH), clear sat_flag, i = 0.
  - Next state is RD_E0 if L >= 2, otherwise DONE (no RAM writes).
- RD_E0: e_en = e_rden = 1, e_addr = i; register e_dout into e0. Next RD_E1.
- RD_E1
  - e_en = e_rden = 1, e_addr = i+1; register into e1.
  - Same cycle: h_en = h_rden = 1, h_addr_b = i; register h_dout into h0.
  - Next CALC.
- CALC: datapath result registered into res; sat_flag |= sat. Next WR.
- WR
  - h_en = h_wren = 1, h_addr_a = i, h_din = res.
  - If i == L-2, next DONE; otherwise i++ and next RD_E0.
- DONE: done = 1 for exactly one cycle. Next IDLE.
- busy = 1 in every state except IDLE. All RAM strobes are 0 outside the states listed above.
- Cycle count:
  - Per cell: 4 cycles.
  - done is high in cycle 4*(L-1)+1 after the start edge for L >= 2, and in cycle 1 for L < 2.
  - H[L-1] is never written (PEC boundary).
- Arithmetic:
  - diff = e1 - e0, sign-extended to FDTD_DATA_WIDTH+1 bits.
  - prod = diff * coef, signed, full width.
  - scaled = prod >>> FRAC_BITS (arithmetic shift, floor).
  - sum = h0 + scaled at full width.
  - res = sum clamped to [-2^(W-1), 2^(W-1)-1]; sat = 1 when clamped.
- Boundaries and concurrency:
  - start while busy is ignored; latched coef and L are unaffected.
  - Changes to cell_num or coef mid-sweep have no effect.
  - cell_num > DEPTH is clamped to DEPTH.
  - cell_num of 0 or 1 produces done with no writes.
  - Reset mid-sweep aborts immediately with no further writes. RAM contents are owned by the RAMs.

Decomposition:
- fdtd_pkg holds: the state enum type (fdtd_upd_state_e), the default width constants (FDTD_DATA_WIDTH, BUFFER_ADDR_WIDTH, COEF_WIDTH, FRAC_BITS), and a saturation-limit localparam function.
- One combinational sub-module, fdtd_sat_mac: inputs e0, e1, h0, coef; outputs res, sat. It is unit-testable in isolation.

Test Plan:
- Basic update: E = {0, 4, 10, ...}, H = 0, coef = 0x08000 (0.5), L = 3, start -> H[0] = 2, H[1] = 3, H[2] = 0. done in cycle 9; busy high for cycles 1-8; sat_flag = 0.
- Negative and floor rounding: E[0] = 5, E[1] = 2, H[0] = 10, coef = 0.5, L = 2 -> H[0] = 8 (scaled = floor(-1.5) = -2).
- Saturation: H[0] = 0x7FFFFFF0, E[0] = 0, E[1] = 0x100, coef = 1.0 (0x10000), L = 2 -> H[0] = 0x7FFFFFFF, sat_flag = 1. The next start clears sat_flag.
- Degenerate lengths: L = 1 -> done in cycle 1, no h_wren ever. L = 0 behaves the same. cell_num = 100 -> clamped to 64, last write at address 62.
- Start while busy: second start pulse in cycle 3 of an L = 3 sweep -> ignored, single done, exactly 2 writes.
- Reset mid-sweep: RST_N low during RD_E1 of cell 1 -> outputs 0 immediately. H[1] keeps its pre-sweep value (in the RAM model if not reset); a fresh start afterwards completes normally.
